wb_cmd_initiator: RTL and testbench
===================================

// Module: wb_cmd_initiator
// PURPOSE
//   Wishbone B4 pipelined initiator: turns single read/write commands from a valid/ready
//   port into single Wishbone transactions (one strobe per cycle). Drives the same bus as
//   the RAM and register peripherals. Returns read data or a timeout error through a
//   one-cycle response pulse. Bridges the SPI command decoder (or a test bench) to the bus.
// PARAMETERS
//   TIMEOUT_CYCLES  15  cycles from wb_cycle_o rise to abort if no ack; legal range >= 1
//   (WB_ADDR_WIDTH, DATA_WIDTH come from common_pkg)
// PORTS
//   wb_clock_i    in   1              bus clock; all logic on its rising edge
//   wb_reset_n_i  in   1              synchronous reset, active low
//   cmd_valid_i   in   1              command present
//   cmd_ready_o   out  1              command accepted when valid && ready at an edge
//   cmd_addr_i    in   WB_ADDR_WIDTH  target bus address
//   cmd_data_i    in   DATA_WIDTH     write data
//   cmd_we_i      in   1              1 = write, 0 = read
//   resp_valid_o  out  1              one-cycle completion pulse
//   resp_data_o   out  DATA_WIDTH     read data; holds last value otherwise
//   resp_err_o    out  1              1 = timed out; valid while resp_valid_o = 1
//   wb_addr_o     out  WB_ADDR_WIDTH  bus address
//   wb_data_o     out  DATA_WIDTH     bus write data
//   wb_data_i     in   DATA_WIDTH     bus read data
//   wb_we_o       out  1              bus write enable
//   wb_cycle_o    out  1              bus cycle
//   wb_strobe_o   out  1              bus strobe
//   wb_stall_i    in   1              peripheral stall
//   wb_ack_i      in   1              peripheral acknowledge
// BEHAVIOUR
//   Reset (wb_reset_n_i = 0 at an edge): all outputs 0 (cmd_ready_o included), state IDLE,
//     timer 0. Takes effect even mid-transaction: cycle/strobe drop, no resp pulse.
//   State machine IDLE -> REQUEST -> WAIT_ACK -> IDLE. Outputs are registered.
//   IDLE: cmd_ready_o = 1 (from the first edge after reset release). On valid && ready:
//     latch addr/data/we into wb_addr_o/wb_data_o/wb_we_o, set wb_cycle_o = wb_strobe_o = 1,
//     cmd_ready_o = 0, timer = 0, go to REQUEST. All three change on the same edge.
//   REQUEST: strobe held, addr/data/we stable. An edge with wb_stall_i = 0 accepts the strobe:
//     wb_strobe_o <= 0, go to WAIT_ACK. While stall = 1 strobe stays high.
//   WAIT_ACK: wb_cycle_o held. An edge with wb_ack_i = 1 completes: wb_cycle_o <= 0,
//     resp_valid_o <= 1, resp_err_o <= 0, resp_data_o <= wb_data_i for reads only (writes
//     leave it unchanged), cmd_ready_o <= 1, go to IDLE.
//   An ack sampled in REQUEST, in the same edge as acceptance, also completes the command.
//   Timer: $clog2(TIMEOUT_CYCLES+1) bits. Increments every edge while wb_cycle_o = 1.
//     When it reaches TIMEOUT_CYCLES without an ack (REQUEST or WAIT_ACK): drop cycle and
//     strobe, resp_valid_o <= 1, resp_err_o <= 1, resp_data_o unchanged, go to IDLE.
//   Ack and timeout on the same edge: ack wins (err = 0).
//   Ack/stall seen in IDLE (e.g. a late ack after timeout) is ignored.
//   resp_valid_o is high exactly one cycle, on the same cycle cmd_ready_o returns to 1.
//   Back-to-back: a new command may be accepted on the edge after resp_valid_o rises.
//     This gives at least 1 idle bus cycle between transactions. One outstanding op max.
//   cmd_* inputs are don't-care when cmd_ready_o = 0.
// TESTING
//   Reset: wb_reset_n_i = 0 for 3 edges with cmd_valid_i = 1 -> cycle/strobe/ready/resp stay 0;
//     cmd_ready_o = 1 one edge after release.
//   Write 0x3A to 0x10010, stall = 0, ack 3 cycles after strobe -> wb_we_o = 1, wb_data_o = 0x3A,
//     strobe high exactly 1 cycle; resp_valid_o 1-cycle pulse, resp_err_o = 0.
//   Read at 0x10020, stall held 2 cycles, then ack with wb_data_i = 0xC5 -> strobe high 3 cycles,
//     address stable; resp_data_o = 0xC5, resp_err_o = 0.
//   No ack, TIMEOUT_CYCLES = 15 -> wb_cycle_o falls 15 edges after rising, resp_err_o = 1.
//     A late ack 2 cycles later is ignored; next read completes normally.
//   Ack on the exact timeout edge -> resp_err_o = 0, data captured.
//   Reset asserted during WAIT_ACK -> wb_cycle_o = 0 next edge, no resp_valid_o pulse.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// Wishbone B4 pipelined initiator: one valid/ready command becomes one single
// bus transaction. It returns read data, or a timeout error, on a one-cycle
// response pulse. All outputs are registered.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned WB_ADDR_WIDTH  = 24,
    parameter int unsigned DATA_WIDTH     = 8
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]    cmd_data_i,
    input  logic                     cmd_we_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_data_o,
    output logic                     resp_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQUEST  = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    logic [1:0]               r_state;
    logic [TW-1:0]            r_timer;
    logic                     r_cmd_ready;
    logic                     r_resp_valid;
    logic [DATA_WIDTH-1:0]    r_resp_data;
    logic                     r_resp_err;
    logic [WB_ADDR_WIDTH-1:0] r_wb_addr;
    logic [DATA_WIDTH-1:0]    r_wb_data;
    logic                     r_wb_we;
    logic                     r_wb_cycle;
    logic                     r_wb_strobe;

    logic w_accept;
    logic w_timeout;
    logic w_done;
    logic w_abort;

    // Decode command acceptance, ack completion and timeout abort for this edge
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid_i;
        // The timer counts edges since cycle rose; this edge is number r_timer + 1
        w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
        // An ack in REQUEST counts only on the edge that also accepts the strobe
        w_done    = ((r_state == ST_REQUEST) && !wb_stall_i && wb_ack_i) ||
                    ((r_state == ST_WAIT_ACK) && wb_ack_i);
        // Ack beats timeout when both land on the same edge
        w_abort   = ((r_state == ST_REQUEST) || (r_state == ST_WAIT_ACK)) &&
                    !w_done && w_timeout;
    end

    // Transaction state machine and all registered outputs
    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_n_i) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_cmd_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_wb_we      <= 1'b0;
            r_wb_cycle   <= 1'b0;
            r_wb_strobe  <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_wb_cycle) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wb_addr   <= cmd_addr_i;
                        r_wb_data   <= cmd_data_i;
                        r_wb_we     <= cmd_we_i;
                        r_wb_cycle  <= 1'b1;
                        r_wb_strobe <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= ST_REQUEST;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_REQUEST, ST_WAIT_ACK: begin
                    if (w_done) begin
                        r_wb_cycle   <= 1'b0;
                        r_wb_strobe  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        if (!r_wb_we) begin
                            r_resp_data <= wb_data_i;
                        end
                        r_state      <= ST_IDLE;
                    end else if (w_abort) begin
                        r_wb_cycle   <= 1'b0;
                        r_wb_strobe  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if ((r_state == ST_REQUEST) && !wb_stall_i) begin
                        r_wb_strobe <= 1'b0;
                        r_state     <= ST_WAIT_ACK;
                    end
                end
                default: begin
                    r_wb_cycle  <= 1'b0;
                    r_wb_strobe <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign resp_err_o   = r_resp_err;
    assign wb_addr_o    = r_wb_addr;
    assign wb_data_o    = r_wb_data;
    assign wb_we_o      = r_wb_we;
    assign wb_cycle_o   = r_wb_cycle;
    assign wb_strobe_o  = r_wb_strobe;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator. Each transaction is described by
// its stall length and ack delay. The expected bus timing and response are
// derived arithmetically from those two numbers and the timeout limit.
module tb_wb_cmd_initiator;

    localparam int T  = 15;
    localparam int AW = 24;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_we;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_dout;
    logic [DW-1:0] wb_din;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_stall;
    logic          wb_ack;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_rdata = '0;

    always #5 clk = ~clk;

    wb_cmd_initiator #(
        .TIMEOUT_CYCLES(T),
        .WB_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .wb_clock_i  (clk),
        .wb_reset_n_i(rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .cmd_we_i    (cmd_we),
        .resp_valid_o(resp_valid),
        .resp_data_o (resp_data),
        .resp_err_o  (resp_err),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_dout),
        .wb_data_i   (wb_din),
        .wb_we_o     (wb_we),
        .wb_cycle_o  (wb_cyc),
        .wb_strobe_o (wb_stb),
        .wb_stall_i  (wb_stall),
        .wb_ack_i    (wb_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One command. Stall is held for s edges after cycle rises; ack arrives a
    // edges after the strobe is accepted (a = 0: on the acceptance edge).
    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int s, input int a, input logic [DW-1:0] rd);
        int   fin;
        int   cyc_cnt;
        int   stb_cnt;
        logic got;
        logic exp_err;
        fin     = s + 1 + a;
        exp_err = (fin > T);
        got     = 1'b0;
        for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_data  = wdata;
        cmd_we    = we;
        wb_stall  = 1'b0;
        wb_ack    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_data  = DW'($urandom);
        cmd_we    = 1'($urandom);
        check("accept_cyc", wb_cyc, 1);
        check("accept_stb", wb_stb, 1);
        check("accept_ready_low", cmd_ready, 0);
        check("accept_addr", wb_addr, addr);
        check("accept_we", wb_we, we);
        check("accept_wdata", wb_dout, wdata);
        cyc_cnt = 1;
        stb_cnt = 1;
        for (int k = 1; k <= 40 && !got; k++) begin
            wb_stall = (k <= s);
            wb_ack   = (k == fin);
            wb_din   = (k == fin) ? rd : DW'($urandom);
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            if (wb_cyc) begin
                cyc_cnt++;
                check("addr_stable", wb_addr, addr);
            end
            if (wb_stb) stb_cnt++;
        end
        wb_stall = 1'b0;
        wb_ack   = 1'b0;
        check("resp_seen", got, 1);
        check("cyc_len", cyc_cnt, imin(fin, T));
        check("stb_len", stb_cnt, imin(s + 1, T));
        check("resp_err", resp_err, exp_err);
        check("ready_with_resp", cmd_ready, 1);
        if (!we && !exp_err) exp_rdata = rd;
        check("resp_data", resp_data, exp_rdata);
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
    endtask

    // Directed scenarios followed by randomized transactions
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 24'h0ABCDE;
        cmd_data  = 8'h55;
        cmd_we    = 1'b1;
        wb_din    = '0;
        wb_stall  = 1'b0;
        wb_ack    = 1'b0;

        // Reset held for 3 edges with a command pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cyc", wb_cyc, 0);
            check("rst_stb", wb_stb, 0);
            check("rst_ready", cmd_ready, 0);
            check("rst_resp", resp_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_cyc", wb_cyc, 0);
        check("post_rst_data", resp_data, 0);
        cmd_valid = 1'b0;

        run_txn(1'b1, 24'h010010, 8'h3A, 0, 2, 8'h00);
        run_txn(1'b0, 24'h010020, 8'h00, 2, 0, 8'hC5);

        // No ack: timeout, then a late ack while idle is ignored
        run_txn(1'b0, 24'h010030, 8'h00, 0, 30, 8'h77);
        @(negedge clk);
        wb_ack = 1'b1;
        wb_din = 8'hEE;
        @(negedge clk);
        wb_ack = 1'b0;
        check("late_ack_no_resp", resp_valid, 0);
        check("late_ack_no_cyc", wb_cyc, 0);
        check("late_ack_data", resp_data, exp_rdata);
        run_txn(1'b0, 24'h010040, 8'h00, 1, 1, 8'h9B);

        // Ack on the exact timeout edge, and timeout while still stalled
        run_txn(1'b0, 24'h010050, 8'h00, 2, 12, 8'h6D);
        run_txn(1'b1, 24'h010060, 8'h11, 16, 0, 8'h00);
        run_txn(1'b0, 24'h010070, 8'h00, 0, 0, 8'h42);

        for (int n = 0; n < 24; n++) begin
            int s;
            int a;
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 16))
                                            : int'($urandom_range(0, 4));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                            : int'($urandom_range(0, 6));
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), s, a, DW'($urandom));
        end

        // Reset during WAIT_ACK drops the cycle with no response
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 24'h010080;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("wait_cyc", wb_cyc, 1);
        check("wait_stb", wb_stb, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cyc", wb_cyc, 0);
        check("midrst_resp", resp_valid, 0);
        check("midrst_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", cmd_ready, 1);
        check("midrst_no_resp", resp_valid, 0);
        run_txn(1'b0, 24'h010090, 8'h00, 1, 2, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
